// File: rtl/apb_rr_arbiter_if.sv
// apb_rr_arbiter_if: requester command/response lines and the APB bus of apb_rr_arbiter.
// master is the arbiter side; slave is the side of the requesters and the APB slave.
interface apb_rr_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0_valid, req0_ready, req0_write, rsp0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req1_valid, req1_ready, req1_write, rsp1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL, PENABLE, PWRITE, PREADY;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA, PRDATA;

    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: two-requester round-robin arbiter sequencing SETUP/ACCESS transfers on one APB bus.
// Define APB_TIMEOUT_EN to abort an ACCESS after TIMEOUT cycles without PREADY (reported via rsp_err).
module apb_rr_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic PCLK,
    input logic PRESET,
    apb_rr_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state_q, state_d;
    logic              last_q, pwrite_q, rsp0_q, rsp1_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q, rdata_q;
    logic              sel, accept, done, tmo, fin;

    // last_q doubles as the owner of the transfer in flight
    always_comb begin
        sel     = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
        accept  = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
        done    = (state_q == ACCESS) && bus.PREADY;
        fin     = done || tmo;
        state_d = (state_q == IDLE)  ? (accept ? SETUP : IDLE) :
                  (state_q == SETUP) ? ACCESS : (fin ? IDLE : ACCESS);
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rsp0_q   <= 1'b0;
            rsp1_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            rsp0_q  <= fin && !last_q;
            rsp1_q  <= fin && last_q;
            if (accept) begin
                last_q   <= sel;
                pwrite_q <= sel ? bus.req1_write : bus.req0_write;
                paddr_q  <= sel ? bus.req1_addr  : bus.req0_addr;
                pwdata_q <= sel ? bus.req1_wdata : bus.req0_wdata;
            end
            if (fin) rdata_q <= (done && !pwrite_q) ? bus.PRDATA : '0;
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;

    // PREADY on the final counted cycle still completes normally
    assign tmo = (state_q == ACCESS) && !bus.PREADY && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == ACCESS) ? cnt_q + CW'(1) : '0;
            if (fin) err_q <= tmo;
        end
    end

    assign bus.rsp_err = err_q;
`else
    // no abort path; TIMEOUT only matters when the counter is built
    assign tmo         = (TIMEOUT < 0);
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req0_ready = accept && !sel;
    assign bus.req1_ready = accept && sel;
    assign bus.rsp0_valid = rsp0_q;
    assign bus.rsp1_valid = rsp1_q;
    assign bus.rsp_rdata  = rdata_q;
    assign bus.PSEL       = (state_q != IDLE);
    assign bus.PENABLE    = (state_q == ACCESS);
    assign bus.PWRITE     = pwrite_q;
    assign bus.PADDR      = paddr_q;
    assign bus.PWDATA     = pwdata_q;
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb_apb_rr_arbiter: scoreboard bench; a memory model predicts responses, a monitor checks the bus timeline.
module tb_apb_rr_arbiter;
    localparam int TIMEOUT = 16;
    typedef struct packed {logic [31:0] rdata; logic err;} exp_t;

    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    apb_rr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
    apb_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (.PCLK(PCLK), .PRESET(PRESET), .bus(bus));

    always #5 PCLK = ~PCLK;

    int          checks = 0, errors = 0;
    exp_t        q0[$], q1[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] smem[logic [31:0]];
    bit          gnt_log[$];
    int          wait_cfg = 0, wl = 0;
    bit          stuck = 0, expect_to = 0;
    int          ph = 0, acc_n = 0;
    bit          last_m = 1, gnt_m = 0, m_sel;
    logic [1:0]  rsp_exp = 0, m_rdy;
    exp_t        m_e;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] pack_log();
        logic [31:0] b = '0;
        foreach (gnt_log[i]) if (i < 32) b[i] = gnt_log[i];
        return {32'(gnt_log.size()), b};
    endfunction

    // Requester N: present a command, wait for ready, predict its response at acceptance
    task automatic issue(input bit n, input bit wr, input logic [31:0] a, input logic [31:0] d, output int waited);
        exp_t e;
        if (n) begin
            bus.req1_valid = 1; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = d;
        end else begin
            bus.req0_valid = 1; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = d;
        end
        waited = 0;
        #1;
        while (!(n ? bus.req1_ready : bus.req0_ready) && waited < 300) begin
            @(posedge PCLK); #2;
            waited++;
        end
        if (waited >= 300) chk("accept_timeout", 64'(waited), 64'(0));
        else begin
            e.err   = expect_to;
            e.rdata = (wr || expect_to) ? '0 : (ref_mem.exists(a) ? ref_mem[a] : '0);
            if (wr && !expect_to) ref_mem[a] = d;
            if (n) q1.push_back(e); else q0.push_back(e);
        end
        @(posedge PCLK); #1;
        if (n) bus.req1_valid = 0; else bus.req0_valid = 0;
    endtask

    task automatic wait_rsp(input bit n, output int cyc);
        cyc = 1;
        while (!(n ? bus.rsp1_valid : bus.rsp0_valid) && cyc < 100) begin
            @(posedge PCLK); #1;
            cyc++;
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || ph != 0) && k < 500) begin
            @(posedge PCLK);
            k++;
        end
        chk("drain", 64'(q0.size() + q1.size()), 64'(0));
        #1;
    endtask

    // APB slave: memory with programmable wait states, garbage PRDATA when not completing a read
    initial begin
        bus.PREADY = 0;
        bus.PRDATA = 0;
        forever begin
            @(posedge PCLK); #2;
            if (!PRESET) begin
                bus.PREADY = 0; wl = 0;
            end else if (bus.PSEL && !bus.PENABLE) begin
                wl = stuck ? 1000000 : (wait_cfg >= 0 ? wait_cfg : int'($urandom_range(0, 3)));
                bus.PREADY = 0;
                bus.PRDATA = $urandom;
            end else if (bus.PSEL) begin
                bus.PREADY = (wl == 0);
                bus.PRDATA = $urandom;
                if (wl > 0) wl--;
                else if (bus.PWRITE) smem[bus.PADDR] = bus.PWDATA;
                else bus.PRDATA = smem.exists(bus.PADDR) ? smem[bus.PADDR] : '0;
            end else begin
                bus.PREADY = 1'($urandom);
                bus.PRDATA = $urandom;
            end
        end
    end

    // Monitor: expected bus timeline, grant rule and scoreboard pops
    initial forever begin
        @(negedge PCLK);
        if (!PRESET) begin
            ph = 0; acc_n = 0; last_m = 1; rsp_exp = 0;
            chk("reset_ctrl", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.req0_ready, bus.req1_ready,
                               bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err}, 0);
            chk("reset_bus", {bus.PADDR, bus.PWDATA}, 0);
            chk("reset_rdata", bus.rsp_rdata, 0);
        end else begin
            chk("psel", bus.PSEL, ph != 0);
            chk("penable", bus.PENABLE, ph == 2);
            chk("rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, rsp_exp);
            if (bus.rsp0_valid) begin
                if (q0.size() == 0) chk("rsp0_unexpected", 64'(q0.size()), 64'(1));
                else begin
                    m_e = q0.pop_front();
                    chk("rsp0_rdata", bus.rsp_rdata, m_e.rdata);
                    chk("rsp0_err", bus.rsp_err, m_e.err);
                end
            end
            if (bus.rsp1_valid) begin
                if (q1.size() == 0) chk("rsp1_unexpected", 64'(q1.size()), 64'(1));
                else begin
                    m_e = q1.pop_front();
                    chk("rsp1_rdata", bus.rsp_rdata, m_e.rdata);
                    chk("rsp1_err", bus.rsp_err, m_e.err);
                end
            end
            m_sel = (bus.req0_valid && bus.req1_valid) ? !last_m : bus.req1_valid;
            m_rdy = (ph == 0 && (bus.req0_valid || bus.req1_valid)) ? (m_sel ? 2'b10 : 2'b01) : 2'b00;
            chk("ready", {bus.req1_ready, bus.req0_ready}, m_rdy);
            rsp_exp = 0;
            if (m_rdy != 0) begin
                gnt_m = m_sel; last_m = m_sel; gnt_log.push_back(m_sel); ph = 1; acc_n = 0;
            end else if (ph == 1) ph = 2;
            else if (ph == 2) begin
                acc_n++;
                if (bus.PREADY) begin
                    ph = 0; rsp_exp = gnt_m ? 2'b10 : 2'b01;
                end
`ifdef APB_TIMEOUT_EN
                else if (acc_n == TIMEOUT) begin
                    ph = 0; rsp_exp = gnt_m ? 2'b10 : 2'b01;
                end
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w0, w1, c;
        bus.req0_valid = 0; bus.req0_write = 0; bus.req0_addr = 0; bus.req0_wdata = 0;
        bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = 0; bus.req1_wdata = 0;
        #1 PRESET = 0;
        repeat (3) @(posedge PCLK);
        #3 PRESET = 1;
        @(posedge PCLK); #1;

        // both valid from reset: req0 first, then req1
        gnt_log.delete();
        fork
            issue(0, 1, 32'h4, 32'h18122023, w0);
            issue(1, 1, 32'h8, 32'h91A0E9A8, w1);
        join
        chk("pair_order", pack_log(), {32'd2, 32'b10});
        issue(0, 0, 32'h4, 0, w);
        issue(1, 0, 32'h8, 0, w);

        // continuous contention alternates
        gnt_log.delete();
        fork
            repeat (3) issue(0, 1'($urandom), 32'($urandom_range(0, 15)) << 2, $urandom, w0);
            repeat (3) issue(1, 1'($urandom), 32'h100 + (32'($urandom_range(0, 15)) << 2), $urandom, w1);
        join
        chk("alternate", pack_log(), {32'd6, 32'b101010});
        drain();

        // zero-wait write then read back
        issue(0, 1, 32'h0, 32'd13, w);
        wait_rsp(0, c);
        chk("wr_latency", 64'(c), 64'(3));
        chk("wr_err", bus.rsp_err, 0);
        issue(0, 0, 32'h0, 0, w);
        wait_rsp(0, c);
        chk("rd_latency", 64'(c), 64'(3));
        chk("rd_13", bus.rsp_rdata, 64'd13);

        // three wait states on a read
        issue(0, 1, 32'hC, 32'h80E0E2F1, w);
        wait_rsp(0, c);
        wait_cfg = 3;
        issue(1, 0, 32'hC, 0, w);
        wait_rsp(1, c);
        chk("stall_latency", 64'(c), 64'(6));
        chk("stall_rdata", bus.rsp_rdata, 64'h80E0E2F1);
        wait_cfg = 0;

        // req1 arrives in the rsp0_valid cycle
        issue(0, 0, 32'h4, 0, w);
        wait_rsp(0, c);
        issue(1, 0, 32'h8, 0, w);
        chk("same_cycle_accept", 64'(w), 64'(0));
        wait_rsp(1, c);
        chk("same_cycle_latency", 64'(c), 64'(3));

        // randomized traffic, disjoint address windows per requester
        wait_cfg = -1;
        fork
            repeat (40) begin
                repeat ($urandom_range(0, 2)) begin @(posedge PCLK); #1; end
                issue(0, 1'($urandom), 32'($urandom_range(0, 15)) << 2, $urandom, w0);
            end
            repeat (40) begin
                repeat ($urandom_range(0, 2)) begin @(posedge PCLK); #1; end
                issue(1, 1'($urandom), 32'h100 + (32'($urandom_range(0, 15)) << 2), $urandom, w1);
            end
        join
        drain();
        wait_cfg = 0;

`ifdef APB_TIMEOUT_EN
        stuck = 1; expect_to = 1;
        issue(0, 0, 32'h4, 0, w);
        wait_rsp(0, c);
        chk("timeout_latency", 64'(c), 64'(TIMEOUT + 2));
        stuck = 0; expect_to = 0;
        issue(0, 0, 32'h4, 0, w);
        wait_rsp(0, c);
        chk("after_timeout_err", bus.rsp_err, 0);
        chk("after_timeout_latency", 64'(c), 64'(3));
`endif

        // reset while in ACCESS
        wait_cfg = 10;
        issue(1, 0, 32'h8, 0, w);
        repeat (2) @(posedge PCLK);
        #3 PRESET = 0;
        #1 chk("async_drop", {bus.PSEL, bus.PENABLE}, 0);
        q0.delete(); q1.delete();
        repeat (2) @(posedge PCLK);
        #3 PRESET = 1;
        wait_cfg = 0;
        @(posedge PCLK); #1;
        gnt_log.delete();
        fork
            issue(0, 1, 32'h20, 32'hA5A5_0001, w0);
            issue(1, 1, 32'h120, 32'h5A5A_0002, w1);
        join
        drain();
        chk("post_reset_order", pack_log(), {32'd2, 32'b10});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
